// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage and a DMA/debug master.
// CPU wins by default; a starvation streak and a bounded DMA lock keep the DMA master moving.
module dm_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_be,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic [31:0]       dma_rdata,
  output logic              dma_rvalid,
  // Data memory port
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  output logic              dm_we,
  input  logic [31:0]       dm_rdata,
  // Debug: 0 = ARB, 1 = LOCKED
  output logic              dbg_state
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int LW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [31:0]     dma_rdata_q, dma_rdata_d;
  logic            dma_rvalid_q, dma_rvalid_d;
  logic            gnt_dma, gnt_cpu;

  // Handshake: a request is a level held with stable fields until served. CPU is served in
  // the cycle cpu_req=1 & cpu_stall=0; DMA in the cycle dma_req=1 & dma_gnt=1. Reads return
  // cpu_rdata in that same cycle, and dma_rdata with a dma_rvalid pulse one cycle later.
  always_comb begin
    gnt_dma = 1'b0;
    gnt_cpu = 1'b0;
    if (reset) begin
      if (state_q == ST_LOCKED) begin
        gnt_dma = dma_req;
      end else begin
        gnt_dma = dma_req & (~cpu_req | (streak_q == STREAK_SAT));
      end
      gnt_cpu = cpu_req & ~gnt_dma;
    end
  end

  assign dma_gnt   = gnt_dma;
  assign cpu_stall = reset & cpu_req & ~gnt_cpu;
  assign cpu_rdata = dm_rdata;

  // With no grant the CPU address still drives the memory so the read path stays warm.
  always_comb begin
    dm_addr  = cpu_addr;
    dm_wdata = cpu_wdata;
    dm_be    = cpu_be;
    dm_we    = 1'b0;
    if (gnt_dma) begin
      dm_addr  = dma_addr;
      dm_wdata = dma_wdata;
      dm_be    = dma_be;
      dm_we    = dma_we;
    end else if (gnt_cpu) begin
      dm_we    = cpu_we;
    end
  end

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    lock_cnt_d   = lock_cnt_q;
    dma_rvalid_d = gnt_dma & ~dma_we;
    dma_rdata_d  = dma_rdata_q;
    if (gnt_dma & ~dma_we) begin
      dma_rdata_d = dm_rdata;
    end
    case (state_q)
      ST_ARB: begin
        if (gnt_dma | ~dma_req) begin
          streak_d = '0;
        end else if (gnt_cpu && streak_q != STREAK_SAT) begin
          streak_d = streak_q + SW'(1);
        end
        if (gnt_dma & dma_lock) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = LW'(1);
        end
      end
      ST_LOCKED: begin
        // Streak is frozen while locked; it was cleared by the entry grant.
        if (~dma_req | ~dma_lock | (lock_cnt_q == LOCK_TOP)) begin
          state_d = ST_ARB;
        end else if (gnt_dma) begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_ARB;
      streak_q     <= '0;
      lock_cnt_q   <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      lock_cnt_q   <= lock_cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dbg_state  = (state_q == ST_LOCKED);

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (12-bit word address, byte-enabled synchronous write, combinational read) between two masters: the CPU memory stage and a DMA/debug master.
- CPU has priority, so loads and stores normally see zero added latency.
- A starvation counter and a bounded DMA lock guarantee forward progress for the DMA master.
- Sits between the memory-stage controller and the DM instance. When the CPU loses arbitration, it raises a stall that freezes the pipeline up to and including the memory stage.

Parameters:
ADDR_W, 12, DM word-address width (byte address bits [13:2]).
STARVE_LIMIT, 4, consecutive CPU grants tolerated while DMA waits before DMA is forced in.
LOCK_MAX, 4, maximum consecutive DMA grants in LOCKED state.

Ports:
clk  in  1  system clock, all state updates on rising edge.
reset  in  1  synchronous, active-low; sampled on rising edge of clk.
cpu_req  in  1  CPU access request, already masked by ADEL/ADES/IntReq and address range; held stable while cpu_stall=1.
cpu_we  in  1  1=write, 0=read.
cpu_addr  in  ADDR_W  word address.
cpu_wdata  in  32  write data.
cpu_be  in  4  byte enables.
cpu_rdata  out  32  read data, combinational; valid in the cycle cpu_req=1 and cpu_stall=0.
cpu_stall  out  1  CPU request not served this cycle.
dma_req  in  1  DMA request; held, with stable fields, until dma_gnt.
dma_we  in  1  1=write.
dma_addr  in  ADDR_W  word address.
dma_wdata  in  32  write data.
dma_be  in  4  byte enables.
dma_lock  in  1  request consecutive ownership, e.g. for read-modify-write.
dma_gnt  out  1  DMA request accepted this cycle.
dma_rdata  out  32  registered read data.
dma_rvalid  out  1  one-cycle pulse; dma_rdata valid.
dm_addr  out  ADDR_W  to DM.
dm_wdata  out  32  to DM.
dm_be  out  4  to DM.
dm_we  out  1  to DM.
dm_rdata  in  32  from DM, combinational.

Behaviour:
- FSM states: ARB and LOCKED. Registers: streak (0..STARVE_LIMIT), lock_cnt (0..LOCK_MAX), dma_rdata, dma_rvalid.
- Reset (reset=0 at edge): state=ARB, streak=0, lock_cnt=0, dma_rvalid=0, dma_rdata=0.
  - While reset=0, the combinational outputs dm_we, dma_gnt and cpu_stall are forced 0.
  - Reset mid-lock abandons the lock. Any DMA read granted in the reset cycle produces no rvalid.
- ARB grant rules:
  - gnt_dma = dma_req & (~cpu_req | streak==STARVE_LIMIT).
  - gnt_cpu = cpu_req & ~gnt_dma.
- LOCKED grant rules:
  - gnt_dma = dma_req.
  - gnt_cpu = cpu_req & ~dma_req.
- cpu_stall = cpu_req & ~gnt_cpu. dma_gnt = gnt_dma.
- DM mux: the granted master drives dm_addr/dm_wdata/dm_be. dm_we = granted master's we.
  - No grant: dm_we=0, dm_addr=cpu_addr.
  - Exactly one master is ever granted per cycle; DM writes are never duplicated.
- cpu_rdata = dm_rdata, zero added latency.
- DMA read: on an edge with gnt_dma & ~dma_we, dma_rdata<=dm_rdata and dma_rvalid<=1. Otherwise dma_rvalid<=0.
- Streak counter:
  - Clears to 0 when gnt_dma=1 or dma_req=0.
  - Increments on gnt_cpu & dma_req, saturating at STARVE_LIMIT.
  - Held in LOCKED.
- Transitions:
  - ARB->LOCKED on gnt_dma & dma_lock; lock_cnt<=1.
  - LOCKED->ARB when ~dma_req | ~dma_lock | lock_cnt==LOCK_MAX, evaluated at the edge.
  - Otherwise, in LOCKED, lock_cnt increments on each gnt_dma.
  - Exit on lock_cnt==LOCK_MAX with dma_req still high: next cycle is ARB with streak=0, so CPU wins if requesting.
  - Total DMA grants per lock ≤ LOCK_MAX+1 (the entry grant plus LOCK_MAX).
- Simultaneous same-address accesses need no hazard handling; they are serialized by grant order.
- Worst-case CPU stall: LOCK_MAX+1 consecutive cycles.
- Worst-case DMA wait: STARVE_LIMIT+1 cycles.

Test Plan:
- Reset held 0 with cpu_req=dma_req=1 and we=1 → dm_we=0, cpu_stall=0, dma_gnt=0. Release → cycle 1 grants CPU, dma_rvalid=0.
- CPU-only: sw addr 0x010 data 0xDEADBEEF be=F, then lw 0x010 → no stall; cpu_rdata=0xDEADBEEF in the load cycle.
- Contention, STARVE_LIMIT=4: cpu_req and dma_req held high continuously → CPU granted cycles 0–3, DMA granted cycle 4 (cpu_stall=1), CPU granted cycle 5; pattern repeats every 5 cycles.
- DMA read addr 0x020 (preloaded 0x12345678) with cpu_req=0 → dma_gnt cycle N; dma_rvalid=1 and dma_rdata=0x12345678 at cycle N+1 only.
- Lock: dma_lock=1 and dma_req=1 for 10 cycles with cpu_req=1, streak already at 4 → DMA granted 5 consecutive cycles, cpu_stall=1 throughout, then CPU granted; FSM back in ARB.
- Byte write: DMA sb be=4'b0100 data 0x00AB0000 to a word holding 0x11223344 → subsequent CPU lw returns 0x11AB3344.
